mem_port_arbiter: RTL

Shares the single SRAM-like memory port of the CPU between the instruction-fetch requester (IF) and the load/store requester (MEM). Sequences one outstanding transaction at a time through an address phase and a data phase. Returns read data to the owning requester. Drives the stall requests that the pipeline controller turns into stall vectors. Sits between the IF/MEM stages and the external bus; it takes `flush` from the pipeline controller.

---
 rtl/mem_port_arbiter.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the CPU's single SRAM-like memory port between
// instruction fetch (IF) and load/store (MEM). One transaction is in flight at
// a time and walks IDLE -> ADDR -> (DATA) -> RESP -> IDLE.
// Optional feature: define MEM_ARB_FAIR_EN to make IF win the next grant after
// a DATA grant whenever both requesters are waiting. Otherwise DATA always wins.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic [DATA_W-1:0] inst_rdata,
    output logic              inst_valid,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic [DATA_W-1:0] data_rdata,
    output logic              data_valid,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [1:0]        mem_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_addr_ok,
    input  logic              mem_data_ok,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stallreq_if,
    output logic              stallreq_mem
);

`ifdef MEM_ARB_FAIR_EN
    localparam bit FAIR_EN = 1'b1;
`else
    localparam bit FAIR_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } state_t;

    // Owner encoding: 0 = instruction fetch, 1 = load/store
    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

    state_t            r_state;
    state_t            w_nextState;
    logic              r_owner;
    logic              r_lastOwner;
    logic              r_discard;
    logic              r_wr;
    logic [1:0]        r_size;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_instValid;
    logic              r_dataValid;
    logic [DATA_W-1:0] r_instRdata;
    logic [DATA_W-1:0] r_dataRdata;

    logic              w_grant;
    logic              w_grantData;
    logic              w_preferInst;
    logic              w_capture;

    // Arbitration: DATA wins unless fairness hands the turn back to IF
    always_comb begin
        w_preferInst = FAIR_EN && (r_lastOwner == OWN_DATA) && inst_req;
        w_grantData  = data_req && !w_preferInst;
        w_grant      = data_req || inst_req;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic, bus request strobe and read-data capture condition
    always_comb begin
        w_nextState = r_state;
        mem_req     = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_grant) begin
                    w_nextState = ADDR;
                end
            end
            ADDR: begin
                mem_req = 1'b1;
                if (mem_addr_ok) begin
                    if (mem_data_ok) begin
                        w_capture   = 1'b1;
                        w_nextState = RESP;
                    end else begin
                        w_nextState = DATA;
                    end
                end
            end
            DATA: begin
                if (mem_data_ok) begin
                    w_capture   = 1'b1;
                    w_nextState = RESP;
                end
            end
            RESP: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Latched request fields, owner tracking, discard flag and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner     <= OWN_INST;
            r_lastOwner <= OWN_INST;
            r_discard   <= 1'b0;
            r_wr        <= 1'b0;
            r_size      <= 2'd0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_instValid <= 1'b0;
            r_dataValid <= 1'b0;
            r_instRdata <= '0;
            r_dataRdata <= '0;
        end else begin
            r_instValid <= 1'b0;
            r_dataValid <= 1'b0;

            if ((r_state == IDLE) && w_grant) begin
                r_owner     <= w_grantData ? OWN_DATA : OWN_INST;
                r_lastOwner <= w_grantData ? OWN_DATA : OWN_INST;
                if (w_grantData) begin
                    r_wr    <= data_wr;
                    r_size  <= data_size;
                    r_addr  <= data_addr;
                    r_wdata <= data_wdata;
                end else begin
                    r_wr    <= 1'b0;
                    r_size  <= 2'd2;
                    r_addr  <= inst_addr;
                    r_wdata <= '0;
                end
            end

            if (((r_state == ADDR) || (r_state == DATA)) && flush && (r_owner == OWN_INST)) begin
                r_discard <= 1'b1;
            end

            if (w_capture) begin
                if (r_owner == OWN_INST) begin
                    if (!r_discard && !flush) begin
                        r_instValid <= 1'b1;
                        r_instRdata <= mem_rdata;
                    end
                end else begin
                    r_dataValid <= 1'b1;
                    if (!r_wr) begin
                        r_dataRdata <= mem_rdata;
                    end
                end
            end

            if (r_state == RESP) begin
                r_discard <= 1'b0;
            end
        end
    end

    // Response outputs; a flush landing on the RESP cycle still kills the IF pulse
    always_comb begin
        mem_wr       = r_wr;
        mem_size     = r_size;
        mem_addr     = r_addr;
        mem_wdata    = r_wdata;
        inst_rdata   = r_instRdata;
        data_rdata   = r_dataRdata;
        inst_valid   = r_instValid && !flush;
        data_valid   = r_dataValid;
        stallreq_if  = inst_req && !inst_valid;
        stallreq_mem = data_req && !data_valid;
    end

endmodule
